dram_master: RTL and testbench
==============================

DRAM_MASTER -- requirements
Module: dram_master

Interface
REQ-001 SHALL have parameter POLL_INTERVAL, default 4: idle cycles between consecutive status polls (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 65535: maximum cycles from the start write to done before the job errors (legal range 1..65535).
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cfg_valid  input  1  host offers a configuration word.
REQ-006 SHALL have port cfg_ready  output  1  block accepts a configuration word.
REQ-007 SHALL have port cfg_data  input  32  configuration word; words arrive in register order 0..8.
REQ-008 SHALL have port ChipSelect  output  1  bus select to the register slave.
REQ-009 SHALL have port Read  output  1  bus read strobe.
REQ-010 SHALL have port Write  output  1  bus write strobe.
REQ-011 SHALL have port Address  output  4  bus register index.
REQ-012 SHALL have port WriteData  output  32  bus write data.
REQ-013 SHALL have port ReadData  input  32  bus read data, combinationally valid in the same cycle as Read.
REQ-014 SHALL have port busy  output  1  high from acceptance of word 8 until job_done or job_error.
REQ-015 SHALL have port job_done  output  1  one-cycle pulse when the slave reports done.
REQ-016 SHALL have port job_error  output  1  one-cycle pulse on timeout.
REQ-017 SHALL have port job_status  output  32  the register-0 value captured at the final poll.

Function
REQ-018 SHALL implement states COLLECT, WRITE, WAIT, POLL and FINISH; all bus outputs SHALL be registered.
REQ-019 COLLECT: cfg_ready=1; each cycle with cfg_valid&cfg_ready SHALL store cfg_data into buf[cnt] and increment cnt; the 9th handshake (cnt=8) SHALL move the state to WRITE with idx=1.
REQ-020 WRITE SHALL issue one write per cycle in address order 1,2,...,8,0, with ChipSelect=1, Write=1, Read=0, Address=idx and WriteData=buf[idx].
REQ-021 The address-0 write SHALL send buf[0] with bit0 forced to 1 (start) and bit31 forced to 0; it SHALL clear the timeout counter and the next state SHALL be WAIT.
REQ-022 WAIT: bus idle (ChipSelect=Read=Write=0, Address=0, WriteData=0) for exactly POLL_INTERVAL cycles, then POLL.
REQ-023 POLL: one cycle with ChipSelect=1, Read=1, Address=0; ReadData SHALL be sampled at that edge.
REQ-024 In POLL, if ReadData[31]=1 the block SHALL load job_status with ReadData and go to FINISH; otherwise it SHALL return to WAIT.
REQ-025 FINISH SHALL last one cycle with job_done=1, busy=0 and cnt=0, then go to COLLECT.
REQ-026 The timeout counter SHALL increment every cycle in WAIT or POLL and saturate; on reaching TIMEOUT it SHALL pulse job_error for one cycle and go to COLLECT, leaving job_status unchanged.
REQ-027 If done (ReadData[31]=1) and timeout occur in the same POLL cycle, done SHALL win.
REQ-028 cfg_ready SHALL be 0 outside COLLECT; cfg_data offered then SHALL be ignored.
REQ-029 Latency: with the 9th handshake at edge T, the first write SHALL occur in cycle T+1, the address-0 write in T+9, and the first poll in T+10+POLL_INTERVAL.

Reset
REQ-030 Reset assertion SHALL immediately force: state=COLLECT, cnt=0, ChipSelect=Read=Write=0, Address=0, WriteData=0, busy=0, job_done=0, job_error=0, job_status=0, cfg_ready=0 while reset is held.
REQ-031 Reset mid-job SHALL abandon the job with no further bus cycles; after release, collection SHALL restart at word 0.

Verification
REQ-032 9 words 0x00000000..0x00000008 accepted back-to-back -> writes to addresses 1..8 carry 1..8, the address-0 write carries 0x00000001, all nine in consecutive cycles.
REQ-033 buf[0]=0x80000000 -> the address-0 write carries 0x00000001 (bit31 cleared, bit0 set).
REQ-034 Slave model sets done after 20 cycles, POLL_INTERVAL=4 -> polls every 5 cycles, job_done pulses once, job_status has bit31=1, busy falls in the same cycle.
REQ-035 TIMEOUT=30, slave never done -> job_error pulses once after 30 WAIT/POLL cycles, no job_done, cfg_ready=1 in the next cycle.
REQ-036 Reset asserted during WRITE at address 4 -> bus outputs 0 immediately; a new 9-word job then completes normally.
REQ-037 cfg_valid toggled randomly, plus words offered while busy -> exactly 9 words captured, in order; none captured while busy.

Source files
------------

// File: rtl/dram_master_if.sv
// dram_master_if: configuration handshake, register bus and job status of dram_master.
interface dram_master_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_data;
    logic        ChipSelect;
    logic        Read;
    logic        Write;
    logic [3:0]  Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        busy;
    logic        job_done;
    logic        job_error;
    logic [31:0] job_status;
    modport master (
        input  cfg_valid, cfg_data, ReadData,
        output cfg_ready, ChipSelect, Read, Write, Address, WriteData,
        output busy, job_done, job_error, job_status
    );
    modport slave (
        output cfg_valid, cfg_data, ReadData,
        input  cfg_ready, ChipSelect, Read, Write, Address, WriteData,
        input  busy, job_done, job_error, job_status
    );
endinterface

// File: rtl/dram_master.sv
// dram_master: collects nine config words, writes them to a register slave, then polls register 0 until done or timeout.
module dram_master #(
    parameter int unsigned POLL_INTERVAL = 4,
    parameter int unsigned TIMEOUT       = 65535
) (
    input logic           clock,
    input logic           reset,
    dram_master_if.master bus
);
    typedef enum logic [2:0] {COLLECT, WRITE, WAIT, POLL, FINISH} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  idx_q;
    logic [31:0] words_q [0:8];
    logic [7:0]  wait_q;
    logic [15:0] tmo_q;
    logic        ready_q;
    logic        cs_q;
    logic        rd_q;
    logic        wr_q;
    logic [3:0]  addr_q;
    logic [31:0] wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] status_q;

    logic        hs;
    logic [3:0]  idx_d;
    logic [31:0] wdata_d;
    logic [15:0] tmo_d;
    logic        tmo_hit;

    assign hs = bus.cfg_valid & ready_q;

    // Address 0 goes last and carries the start bit with the done bit cleared.
    always_comb begin
        idx_d   = (idx_q == 4'd8) ? 4'd0 : idx_q + 4'd1;
        wdata_d = (idx_d == 4'd0) ? {1'b0, words_q[0][30:1], 1'b1} : words_q[idx_d];
        tmo_d   = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
        tmo_hit = {16'd0, tmo_d} >= TIMEOUT;
    end

    always_ff @(posedge clock) begin
        if (hs)
            words_q[cnt_q] <= bus.cfg_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= COLLECT;
            cnt_q    <= 4'd0;
            idx_q    <= 4'd0;
            wait_q   <= 8'd0;
            tmo_q    <= 16'd0;
            ready_q  <= 1'b0;
            cs_q     <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= 4'd0;
            wdata_q  <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            status_q <= 32'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                COLLECT: begin
                    ready_q <= !(hs && cnt_q == 4'd8);
                    if (hs) begin
                        cnt_q <= (cnt_q == 4'd8) ? 4'd0 : cnt_q + 4'd1;
                        if (cnt_q == 4'd8) begin
                            state_q <= WRITE;
                            busy_q  <= 1'b1;
                            idx_q   <= 4'd1;
                            cs_q    <= 1'b1;
                            wr_q    <= 1'b1;
                            addr_q  <= 4'd1;
                            wdata_q <= words_q[1];
                        end
                    end
                end
                WRITE: begin
                    if (idx_q == 4'd0) begin
                        state_q <= WAIT;
                        wait_q  <= 8'd0;
                        tmo_q   <= 16'd0;
                        cs_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        addr_q  <= 4'd0;
                        wdata_q <= 32'd0;
                    end else begin
                        idx_q   <= idx_d;
                        addr_q  <= idx_d;
                        wdata_q <= wdata_d;
                    end
                end
                WAIT: begin
                    tmo_q <= tmo_d;
                    if (tmo_hit) begin
                        state_q <= COLLECT;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (wait_q == 8'(POLL_INTERVAL - 1)) begin
                        state_q <= POLL;
                        cs_q    <= 1'b1;
                        rd_q    <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                POLL: begin
                    tmo_q  <= tmo_d;
                    wait_q <= 8'd0;
                    cs_q   <= 1'b0;
                    rd_q   <= 1'b0;
                    // done takes priority over a timeout expiring on the same poll
                    if (bus.ReadData[31]) begin
                        state_q  <= FINISH;
                        status_q <= bus.ReadData;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                    end else if (tmo_hit) begin
                        state_q <= COLLECT;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                FINISH: begin
                    state_q <= COLLECT;
                    cnt_q   <= 4'd0;
                    ready_q <= 1'b1;
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.cfg_ready  = ready_q;
    assign bus.ChipSelect = cs_q;
    assign bus.Read       = rd_q;
    assign bus.Write      = wr_q;
    assign bus.Address    = addr_q;
    assign bus.WriteData  = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.job_done   = done_q;
    assign bus.job_error  = err_q;
    assign bus.job_status = status_q;
endmodule

// File: tb/tb_dram_master.sv
// tb_dram_master: directed jobs against dram_master with a register-slave model whose done bit rises a set number of cycles after the start write.
module tb_dram_master;
    localparam int PI = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dram_master_if bif ();
    dram_master #(.POLL_INTERVAL(PI), .TIMEOUT(30)) dut (.clock(clock), .reset(reset), .bus(bif));

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          k = 0;
    int          done_after = 20;
    logic [31:0] done_word = 32'h8000_00A5;
    assign bif.ReadData = (k >= done_after) ? done_word : 32'h0000_0012;

    logic [31:0] wr_data [9];
    int          wr_cyc [9];
    int          n_wr, seq_bad, polls, poll_bad, last_poll_k, first_poll_cyc;
    int          n_done, done_k, n_err, err_k, busy_cap, hs_cyc;
    logic        done_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_wr(input logic [31:0] w [9], input int j);
        logic [31:0] s;
        s = w[0];
        s[0] = 1'b1;
        s[31] = 1'b0;
        return (j < 8) ? w[j+1] : s;
    endfunction

    always @(posedge clock) cyc++;

    always @(negedge clock) if (!reset) begin
        k++;
        if (bif.ChipSelect && bif.Write) begin
            if (n_wr < 9) begin
                if (int'(bif.Address) != ((n_wr == 8) ? 0 : n_wr + 1)) seq_bad++;
                wr_data[n_wr] = bif.WriteData;
                wr_cyc[n_wr] = cyc;
                n_wr++;
            end
            if (bif.Address == 4'd0) k = 0;
        end
        if (bif.ChipSelect && bif.Read) begin
            if (polls == 0) first_poll_cyc = cyc;
            else if (k - last_poll_k != PI + 1) poll_bad++;
            last_poll_k = k;
            polls++;
        end
        if (bif.job_done) begin n_done++; done_k = k; done_busy = bif.busy; end
        if (bif.job_error) begin n_err++; err_k = k; end
        if (bif.busy && bif.cfg_ready) busy_cap++;
    end

    task automatic clear_mon();
        n_wr = 0; seq_bad = 0; polls = 0; poll_bad = 0; last_poll_k = 0; first_poll_cyc = -1;
        n_done = 0; done_k = -1; n_err = 0; err_k = -1; busy_cap = 0; k = 0;
    endtask

    task automatic send_words(input logic [31:0] w [9], input bit rnd, input logic [31:0] junk);
        int i = 0;
        int g = 0;
        while (i < 9 && g < 300) begin
            @(negedge clock);
            bif.cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bif.cfg_data = bif.cfg_valid ? w[i] : 32'hBAD0_0000;
            if (bif.cfg_valid && bif.cfg_ready) begin
                if (i == 8) hs_cyc = cyc + 1;
                i++;
            end
            g++;
        end
        @(negedge clock);
        check("words_accepted", i, 9);
        check("busy_start", {bif.busy, bif.cfg_ready}, 2'b10);
        bif.cfg_valid = (junk != 0);
        bif.cfg_data = junk;
    endtask

    task automatic wait_end(input int budget);
        int g = 0;
        while (!(bif.job_done || bif.job_error) && g < budget) begin
            @(negedge clock);
            g++;
        end
        check("job_end_seen", g < budget, 1);
        bif.cfg_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input logic [31:0] w [9]);
        check({tag, "_n_wr"}, n_wr, 9);
        check({tag, "_order"}, seq_bad, 0);
        for (int j = 0; j < 9; j++) check($sformatf("%s_wr%0d", tag, j), wr_data[j], exp_wr(w, j));
    endtask

    logic [31:0] wa [9] = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
    logic [31:0] wb [9] = '{32'h8000_0000, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7, 32'hA8};
    logic [31:0] wc [9] = '{32'h0000_0002, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5, 32'hC6, 32'hC7, 32'hC8};
    logic [31:0] we [9] = '{32'h0000_1234, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004,
                            32'h5555_0005, 32'h6666_0006, 32'h7777_0007, 32'h8888_0008};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bif.cfg_valid = 1'b0;
        bif.cfg_data = 32'h0;
        clear_mon();
        repeat (2) @(negedge clock);
        check("rst_bus", {bif.ChipSelect, bif.Read, bif.Write, bif.Address}, 0);
        check("rst_wdata", bif.WriteData, 0);
        check("rst_status", bif.job_status, 0);
        check("rst_ctl", {bif.busy, bif.job_done, bif.job_error, bif.cfg_ready}, 0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", bif.cfg_ready, 1);

        // back-to-back words, done after 20 cycles
        clear_mon();
        done_after = 20; done_word = 32'h8000_00A5;
        send_words(wa, 0, 0);
        wait_end(200);
        repeat (6) @(negedge clock);
        check_writes("A", wa);
        check("A_first_wr_cyc", wr_cyc[0], hs_cyc);
        check("A_addr0_cyc", wr_cyc[8], hs_cyc + 8);
        check("A_first_poll_cyc", first_poll_cyc, hs_cyc + 9 + PI);
        check("A_polls", polls, 4);
        check("A_poll_spacing", poll_bad, 0);
        check("A_n_done", n_done, 1);
        check("A_n_err", n_err, 0);
        check("A_done_k", done_k, 21);
        check("A_busy_at_done", done_busy, 0);
        check("A_status", bif.job_status, 32'h8000_00A5);
        check("A_ready_idle", bif.cfg_ready, 1);

        // bit31 of word 0 cleared; done and timeout on the same poll
        clear_mon();
        done_after = 30; done_word = 32'h8000_0B0B;
        send_words(wb, 0, 0);
        wait_end(200);
        repeat (6) @(negedge clock);
        check("B_addr0_wr", wr_data[8], 32'h0000_0001);
        check("B_wr0", wr_data[0], 32'hA1);
        check("B_n_done", n_done, 1);
        check("B_n_err", n_err, 0);
        check("B_done_k", done_k, 31);
        check("B_status", bif.job_status, 32'h8000_0B0B);

        // slave never done: timeout
        clear_mon();
        done_after = 100000; done_word = 32'h8000_0C0C;
        send_words(wc, 0, 0);
        wait_end(200);
        check("C_err_busy", {bif.job_error, bif.busy}, 2'b10);
        @(negedge clock);
        check("C_ready_after_err", {bif.cfg_ready, bif.job_error}, 2'b10);
        repeat (5) @(negedge clock);
        check("C_addr0_wr", wr_data[8], 32'h0000_0003);
        check("C_n_err", n_err, 1);
        check("C_n_done", n_done, 0);
        check("C_err_k", err_k, 31);
        check("C_polls", polls, 6);
        check("C_status_kept", bif.job_status, 32'h8000_0B0B);

        // reset while writing address 4
        clear_mon();
        done_after = 20; done_word = 32'h8000_0D0D;
        send_words(wa, 0, 0);
        begin
            int g = 0;
            while (!(bif.Write && bif.Address == 4'd4) && g < 20) begin
                @(negedge clock);
                g++;
            end
            check("D_saw_addr4", g < 20, 1);
        end
        reset = 1'b1;
        #1;
        check("D_rst_bus", {bif.ChipSelect, bif.Read, bif.Write, bif.Address}, 0);
        check("D_rst_wdata", bif.WriteData, 0);
        check("D_rst_ctl", {bif.busy, bif.cfg_ready}, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        clear_mon();
        repeat (6) @(negedge clock);
        check("D_no_bus_after", n_wr + polls, 0);

        // random valid gaps, junk offered while busy
        clear_mon();
        done_after = 20; done_word = 32'h8123_4567;
        send_words(we, 1, 32'hDEAD_BEEF);
        wait_end(200);
        repeat (6) @(negedge clock);
        check_writes("E", we);
        check("E_addr0_wr", wr_data[8], 32'h0000_1235);
        check("E_ready_while_busy", busy_cap, 0);
        check("E_n_done", n_done, 1);
        check("E_status", bif.job_status, 32'h8123_4567);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
